// File: rtl/cpu.sv
// Multi-cycle RV32I integer core, one instruction in flight.
// Non-load instructions retire in a single EXEC cycle; loads take an extra
// LOAD_WB cycle because the data RAM returns read data one clock late.
//
// Data port handshake: there is no valid/ready pair. The RAM is always ready:
// data_wr_en != 0 in a cycle commits that store at the next rising edge, and
// whatever address is on data_addr at an edge is returned on data_rd during
// the following cycle.
module cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  output logic [31:0] data_addr,
  input  logic [31:0] data_rd,
  output logic [31:0] data_wr,
  output logic [3:0]  data_wr_en
);

  typedef enum logic {
    EXEC    = 1'b0,
    LOAD_WB = 1'b1
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Architectural state, named so that benches can inspect it directly.
  state_t      state;
  logic [31:0] pc;
  logic [31:0] xreg [0:31];

  // Load bookkeeping captured in EXEC and consumed in LOAD_WB.
  logic [4:0]  ld_rd_q;
  logic [2:0]  ld_f3_q;
  logic [1:0]  ld_off_q;
  logic [29:0] ld_word_q;

  // Instruction fields.
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, ea;

  assign opcode = inst_data[6:0];
  assign rd     = inst_data[11:7];
  assign funct3 = inst_data[14:12];
  assign rs1    = inst_data[19:15];
  assign rs2    = inst_data[24:20];
  assign imm_i  = {{20{inst_data[31]}}, inst_data[31:20]};
  assign imm_s  = {{20{inst_data[31]}}, inst_data[31:25], inst_data[11:7]};
  assign imm_b  = {{19{inst_data[31]}}, inst_data[31], inst_data[7],
                   inst_data[30:25], inst_data[11:8], 1'b0};
  assign imm_u  = {inst_data[31:12], 12'h000};
  assign imm_j  = {{11{inst_data[31]}}, inst_data[31], inst_data[19:12],
                   inst_data[20], inst_data[30:21], 1'b0};

  assign rs1_val = (rs1 == 5'd0) ? 32'h0 : xreg[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'h0 : xreg[rs2];
  assign ea      = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);

  assign inst_addr = pc;

  // Shared ALU for register-immediate and register-register operations.
  function automatic logic [31:0] alu(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b, input logic alt);
    logic [31:0] r;
    r = 32'h0;
    case (f3)
      3'b000: r = alt ? (a - b) : (a + b);
      3'b001: r = a << b[4:0];
      3'b010: r = {31'h0, $signed(a) < $signed(b)};
      3'b011: r = {31'h0, a < b};
      3'b100: r = a ^ b;
      3'b101: r = alt ? ($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Branch condition evaluation.
  logic br_taken;
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000: br_taken = (rs1_val == rs2_val);
      3'b001: br_taken = (rs1_val != rs2_val);
      3'b100: br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101: br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110: br_taken = (rs1_val <  rs2_val);
      3'b111: br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Lane selection and extension of the returned load word.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  always_comb begin
    ld_byte = 8'(data_rd >> {ld_off_q, 3'b000});
    ld_half = 16'(data_rd >> {ld_off_q[1], 4'b0000});
    case (ld_f3_q)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'h0, ld_byte};
      3'b101:  ld_val = {16'h0, ld_half};
      default: ld_val = data_rd;
    endcase
  end

  // Next-state, writeback and data-port decode.
  state_t      state_next;
  logic [31:0] pc_next;
  logic        rd_we;
  logic [4:0]  rd_idx;
  logic [31:0] rd_val;
  logic        ld_capture;
  always_comb begin
    state_next = state;
    pc_next    = pc + 32'd4;
    rd_we      = 1'b0;
    rd_idx     = rd;
    rd_val     = 32'h0;
    ld_capture = 1'b0;
    data_addr  = {2'b00, ea[31:2]};
    data_wr    = 32'h0;
    data_wr_en = 4'b0000;
    if (state == LOAD_WB) begin
      data_addr  = {2'b00, ld_word_q};
      rd_we      = 1'b1;
      rd_idx     = ld_rd_q;
      rd_val     = ld_val;
      state_next = EXEC;
    end else begin
      case (opcode)
        OP_LUI:   begin rd_we = 1'b1; rd_val = imm_u; end
        OP_AUIPC: begin rd_we = 1'b1; rd_val = pc + imm_u; end
        OP_JAL: begin
          rd_we   = 1'b1;
          rd_val  = pc + 32'd4;
          pc_next = pc + imm_j;
        end
        OP_JALR: begin
          rd_we   = 1'b1;
          rd_val  = pc + 32'd4;
          pc_next = (rs1_val + imm_i) & ~32'd1;
        end
        OP_BRANCH: if (br_taken) pc_next = pc + imm_b;
        OP_LOAD: begin
          pc_next    = pc;
          state_next = LOAD_WB;
          ld_capture = 1'b1;
        end
        OP_STORE: begin
          case (funct3)
            3'b000: begin
              data_wr    = {4{rs2_val[7:0]}};
              data_wr_en = 4'b0001 << ea[1:0];
            end
            3'b001: begin
              data_wr    = {2{rs2_val[15:0]}};
              data_wr_en = ea[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
              data_wr    = rs2_val;
              data_wr_en = 4'b1111;
            end
            default: ;
          endcase
        end
        OP_IMM: begin
          rd_we  = 1'b1;
          rd_val = alu(funct3, rs1_val, imm_i, (funct3 == 3'b101) && inst_data[30]);
        end
        OP_REG: begin
          rd_we  = 1'b1;
          rd_val = alu(funct3, rs1_val, rs2_val, inst_data[30]);
        end
        default: ;
      endcase
    end
    // No byte lane may be enabled while the core is held in reset.
    if (!rst_n) data_wr_en = 4'b0000;
  end

  // State register: pc, FSM state, register file and load bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EXEC;
      pc        <= RESET_PC;
      ld_rd_q   <= 5'd0;
      ld_f3_q   <= 3'd0;
      ld_off_q  <= 2'd0;
      ld_word_q <= 30'd0;
      for (int i = 0; i < 32; i++) xreg[i] <= 32'h0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (rd_we && (rd_idx != 5'd0)) xreg[rd_idx] <= rd_val;
      if (ld_capture) begin
        ld_rd_q   <= rd;
        ld_f3_q   <= funct3;
        ld_off_q  <= ea[1:0];
        ld_word_q <= ea[31:2];
      end
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Directed bench for the cpu core: drives instruction words directly,
// models a small word-addressed RAM with byte lanes, and checks pc,
// register file, RAM contents and the write-enable port.
module tb_cpu;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic [31:0] data_addr;
  logic [31:0] data_rd;
  logic [31:0] data_wr;
  logic [3:0]  data_wr_en;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] mem [0:15];

  localparam logic [31:0] NOP = 32'h0000_0013;

  cpu #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_addr  (inst_addr),
    .inst_data  (inst_data),
    .data_addr  (data_addr),
    .data_rd    (data_rd),
    .data_wr    (data_wr),
    .data_wr_en (data_wr_en)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read-before-write, data returned one clock later.
  always @(posedge clk) begin
    data_rd = mem[data_addr[3:0]];
    for (int b = 0; b < 4; b++)
      if (data_wr_en[b]) mem[data_addr[3:0]][8*b +: 8] = data_wr[8*b +: 8];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Execute a single-cycle, fall-through instruction.
  task automatic run_inst(input logic [31:0] ins, input string tag);
    inst_data = ins;
    @(posedge clk); #1;
    exp_pc = exp_pc + 32'd4;
    check({tag, "_pc"}, dut.pc, exp_pc);
  endtask

  // Execute a load into x3 and check both cycles.
  task automatic do_load(input logic [31:0] ins, input logic [31:0] exp, input string tag);
    inst_data = ins;
    @(posedge clk); #1;
    check({tag, "_state"}, {31'h0, dut.state}, 32'd1);
    check({tag, "_pc_hold"}, dut.pc, exp_pc);
    @(posedge clk); #1;
    exp_pc = exp_pc + 32'd4;
    check({tag, "_x3"}, dut.xreg[3], exp);
    check({tag, "_pc"}, dut.pc, exp_pc);
  endtask

  // Execute a store at x0+k and check the enables and the resulting word.
  task automatic do_store(input logic [31:0] ins, input logic [3:0] en,
                          input logic [31:0] exp, input string tag);
    mem[0] = 32'hFFFF_FFFF;
    inst_data = ins;
    #1;
    check({tag, "_en"}, {28'h0, data_wr_en}, {28'h0, en});
    @(posedge clk); #1;
    exp_pc = exp_pc + 32'd4;
    check({tag, "_mem"}, mem[0], exp);
  endtask

  initial begin
    logic [31:0] sb_ins [0:3];
    logic [31:0] sb_exp [0:3];
    logic [31:0] lb_exp [0:3];
    sb_ins = '{32'h0020_0023, 32'h0020_00A3, 32'h0020_0123, 32'h0020_01A3};
    sb_exp = '{32'hFFFF_FF01, 32'hFFFF_01FF, 32'hFF01_FFFF, 32'h01FF_FFFF};
    lb_exp = '{32'hFFFF_FFC0, 32'hFFFF_FFB0, 32'hFFFF_FFA0, 32'hFFFF_FF90};
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    // Reset with a store on the instruction bus: no lane may be enabled.
    rst_n = 1'b0;
    inst_data = 32'h0020_2023;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", dut.pc, 32'h0);
    check("rst_x1", dut.xreg[1], 32'h0);
    check("rst_state", {31'h0, dut.state}, 32'h0);
    check("rst_wr_en", {28'h0, data_wr_en}, 32'h0);
    check("rst_inst_addr", inst_addr, 32'h0);
    inst_data = NOP;
    rst_n = 1'b1;
    exp_pc = 32'h0;

    run_inst(NOP, "nop");
    check("nop_x1", dut.xreg[1], 32'h0);
    check("nop_wr_en", {28'h0, data_wr_en}, 32'h0);
    run_inst(32'h0340_0093, "addi_x1");
    check("addi_x1_val", dut.xreg[1], 32'h0000_0034);
    run_inst(32'h0050_0013, "addi_x0");
    check("addi_x0_val", dut.xreg[0], 32'h0);
    run_inst(32'h0010_0113, "addi_x2");
    check("addi_x2_val", dut.xreg[2], 32'h1);

    // Byte, half and word stores of x2 = 1 into an all-ones word.
    for (int k = 0; k < 4; k++)
      do_store(sb_ins[k], 4'(4'b0001 << k), sb_exp[k], $sformatf("sb%0d", k));
    do_store(32'h0020_1023, 4'b0011, 32'hFFFF_0001, "sh0");
    do_store(32'h0020_1123, 4'b1100, 32'h0001_FFFF, "sh2");
    do_store(32'h0020_2023, 4'b1111, 32'h0000_0001, "sw");
    check("st_pc", dut.pc, exp_pc);
    run_inst(NOP, "nop_after_st");
    check("nop_after_st_en", {28'h0, data_wr_en}, 32'h0);

    // Loads with sign and zero extension.
    mem[0] = 32'h90A0_B0C0;
    for (int k = 0; k < 4; k++)
      do_load(32'h0000_0183 | (32'(k) << 20), lb_exp[k], $sformatf("lb%0d", k));
    do_load(32'h0030_4183, 32'h0000_0090, "lbu3");
    do_load(32'h0000_2183, 32'h90A0_B0C0, "lw");
    mem[0] = 32'h91A1_B1C1;
    do_load(32'h0020_1183, 32'hFFFF_91A1, "lh2");
    do_load(32'h0000_5183, 32'h0000_B1C1, "lhu0");

    // Round trip through memory.
    run_inst(32'h0102_0237, "lui_x4");
    run_inst(32'h3042_0213, "addi_x4");
    check("x4_val", dut.xreg[4], 32'h0102_0304);
    run_inst(32'h0040_2023, "sw_x4");
    check("sw_x4_mem", mem[0], 32'h0102_0304);
    do_load(32'h0000_4183, 32'h0000_0004, "rt_lbu0");
    do_load(32'h0010_4183, 32'h0000_0003, "rt_lbu1");
    do_load(32'h0020_4183, 32'h0000_0002, "rt_lbu2");
    do_load(32'h0030_4183, 32'h0000_0001, "rt_lbu3");
    do_load(32'h0000_5183, 32'h0000_0304, "rt_lhu0");
    do_load(32'h0020_5183, 32'h0000_0102, "rt_lhu2");
    run_inst(32'h1020_0293, "addi_x5");
    run_inst(32'h0050_1023, "sh_x5");
    check("sh_x5_mem", mem[0], 32'h0102_0102);
    do_load(32'h0000_5183, 32'h0000_0102, "rt_sh_lhu0");

    // SUB and a taken branch.
    run_inst(32'h4022_0333, "sub");
    check("sub_x6", dut.xreg[6], 32'h0102_0303);
    inst_data = 32'h0000_0463;
    @(posedge clk); #1;
    exp_pc = exp_pc + 32'd8;
    check("beq_pc", dut.pc, exp_pc);

    // Reset pulse, then jumps.
    rst_n = 1'b0;
    #2;
    check("rst2_pc", dut.pc, 32'h0);
    check("rst2_x4", dut.xreg[4], 32'h0);
    @(posedge clk); #1;
    inst_data = NOP;
    rst_n = 1'b1;
    exp_pc = 32'h0;
    for (int k = 0; k < 5; k++) run_inst(NOP, $sformatf("nop_j%0d", k));
    inst_data = 32'hFEDF_F06F;
    @(posedge clk); #1;
    check("jal_back_pc", dut.pc, 32'h0);
    inst_data = 32'h0080_00EF;
    @(posedge clk); #1;
    check("jal_fwd_pc", dut.pc, 32'h8);
    check("jal_fwd_x1", dut.xreg[1], 32'h4);

    // Reset asserted during LOAD_WB aborts the writeback.
    mem[0] = 32'hDEAD_BEEF;
    inst_data = 32'h0000_2183;
    @(posedge clk); #1;
    check("abort_state_wb", {31'h0, dut.state}, 32'd1);
    rst_n = 1'b0;
    #2;
    check("abort_pc", dut.pc, 32'h0);
    check("abort_state", {31'h0, dut.state}, 32'h0);
    @(posedge clk); #1;
    check("abort_x3", dut.xreg[3], 32'h0);
    inst_data = NOP;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_after_x3", dut.xreg[3], 32'h0);
    check("abort_after_pc", dut.pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
